prop_chain_pipe: RTL and testbench

Parametrised, registered propagation chain: a DEPTH-stage elastic valid/ready pipeline where every stage applies the same unary operator (copy, logical-not, bitwise-not or increment) to the previous stage's value. It generalises the combinational two-deep assignment chains used in the scheduling tests into a clocked, back-pressurable block. Every intermediate value is exposed on a tap bus, so benches can check propagation stage by stage against a cycle-exact model.

---
 rtl/prop_chain_pipe.sv | 112 +++++++++++
 tb/tb_prop_chain_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prop_chain_pipe.sv
// prop_chain_pipe: DEPTH-stage elastic valid/ready pipeline. Every stage applies the
// same unary operator (selected by MODE) to the value coming from the stage before it.
// Every stage value is visible on taps. occupancy is a registered count of valid stages.
module prop_chain_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int MODE  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [DEPTH*WIDTH-1:0]     taps,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    // Per-stage operator. Plain 4-state operators are used, so X/Z inputs propagate untouched.
    function automatic logic [WIDTH-1:0] stage_op(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        r = x;
        case (MODE)
            1: begin
                r    = '0;
                r[0] = (x == '0);
            end
            2:       r = ~x;
            3:       r = x + WIDTH'(1);
            default: r = x;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] data_reg  [DEPTH];
    logic [WIDTH-1:0] data_next [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] valid_next;
    logic [DEPTH-1:0] valid_in;
    logic [DEPTH-1:0] adv;
    logic             adv_carry;
    logic [OCC_W-1:0] occ_reg;
    logic [OCC_W-1:0] occ_next;
    logic             in_beat;
    logic             out_beat;

    // The advance chain is built back to front. A stage moves when it is empty or when the stage after it moves.
    always_comb begin
        adv       = '0;
        adv_carry = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            adv[k]    = !valid_reg[k] || adv_carry;
            adv_carry = adv[k];
        end
    end

    assign in_ready  = adv[0] && !flush;
    assign in_beat   = in_valid && in_ready;
    assign out_valid = valid_reg[DEPTH-1];
    assign out_beat  = out_valid && out_ready;
    assign out_data  = data_reg[DEPTH-1];
    assign occupancy = occ_reg;

    // Per-stage source selection, operator, and tap exposure.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] src;
        if (gi == 0) begin : g_first
            assign src          = in_data;
            assign valid_in[gi] = in_beat;
        end else begin : g_rest
            assign src          = data_reg[gi-1];
            assign valid_in[gi] = valid_reg[gi-1];
        end
        assign data_next[gi]              = stage_op(src);
        assign taps[gi*WIDTH +: WIDTH]    = data_reg[gi];
    end

    // Next valids and occupancy. A flush clears everything, and the count tracks beats in and out.
    always_comb begin
        valid_next = (adv & valid_in) | (~adv & valid_reg);
        occ_next   = occ_reg + OCC_W'(in_beat) - OCC_W'(out_beat);
        if (flush) begin
            valid_next = '0;
            occ_next   = '0;
        end
    end

    // Stage registers. Data loads only on advance and stays unchanged through a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            occ_reg   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_reg[k] <= '0;
            end
        end else begin
            valid_reg <= valid_next;
            occ_reg   <= occ_next;
            for (int k = 0; k < DEPTH; k++) begin
                if (adv[k] && !flush) begin
                    data_reg[k] <= data_next[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_prop_chain_pipe.sv
// Testbench for prop_chain_pipe. Three instances (MODE 3, 2, 1) share one stimulus.
// A count-based scoreboard predicts in_ready and occupancy every cycle and checks output order and values.
module tb_prop_chain_pipe;

    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, flush, in_valid, out_ready;
    logic [W-1:0] in_data;

    logic         in_ready3, in_ready2, in_ready1;
    logic         out_valid3, out_valid2, out_valid1;
    logic [W-1:0] out_data3, out_data2, out_data1;
    logic [D*W-1:0] taps3, taps2, taps1;
    logic [2:0]   occupancy3, occupancy2, occupancy1;

    prop_chain_pipe #(.WIDTH(W), .DEPTH(D), .MODE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready3),
        .in_data(in_data), .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
        .taps(taps3), .occupancy(occupancy3));

    prop_chain_pipe #(.WIDTH(W), .DEPTH(D), .MODE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .taps(taps2), .occupancy(occupancy2));

    prop_chain_pipe #(.WIDTH(W), .DEPTH(D), .MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .taps(taps1), .occupancy(occupancy1));

    typedef struct packed {
        logic [7:0] e3;
        logic [7:0] e2;
        logic [7:0] e1;
    } exp_t;

    typedef struct {
        logic [7:0]      din;
        logic [3:0][7:0] t3;
        logic [3:0][7:0] t2;
        logic [3:0][7:0] t1;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_cnt = 0;

    logic           s_in_beat;
    logic           s_ov3, s_ov2, s_ov1;
    logic [2:0]     s_occ;
    logic [D*W-1:0] s_taps3, s_taps2, s_taps1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] f_op(input int mode, input logic [7:0] x);
        case (mode)
            1:       return (x == 8'h00) ? 8'h01 : 8'h00;
            2:       return ~x;
            3:       return x + 8'h01;
            default: return x;
        endcase
    endfunction

    function automatic logic [7:0] f_chain(input int mode, input logic [7:0] x);
        logic [7:0] v;
        v = x;
        for (int i = 0; i < D; i++) v = f_op(mode, v);
        return v;
    endfunction

    // One clock cycle: sample on the falling edge, score against the model, then step past the rising edge.
    task automatic cycle();
        logic exp_rdy;
        logic ob;
        exp_t e;
        @(negedge clk);
        s_ov3   = out_valid3;
        s_ov2   = out_valid2;
        s_ov1   = out_valid1;
        s_occ   = occupancy3;
        s_taps3 = taps3;
        s_taps2 = taps2;
        s_taps1 = taps1;
        exp_rdy = !flush && ((model_cnt < D) || out_ready);
        check("in_ready_m3", in_ready3, exp_rdy);
        check("in_ready_m2", in_ready2, exp_rdy);
        check("in_ready_m1", in_ready1, exp_rdy);
        check("occupancy_m3", occupancy3, model_cnt);
        check("occupancy_m2", occupancy2, model_cnt);
        check("occupancy_m1", occupancy1, model_cnt);
        if (model_cnt == 0) check("out_valid_when_empty", out_valid3, 0);
        s_in_beat = in_valid && exp_rdy;
        ob = out_valid3 && out_ready;
        if (ob) begin
            check("output_has_pending", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_data_m3", out_data3, e.e3);
                check("out_data_m2", out_data2, e.e2);
                check("out_data_m1", out_data1, e.e1);
                $display("out beat m3=%02h m2=%02h m1=%02h", out_data3, out_data2, out_data1);
            end
        end
        if (flush) begin
            model_cnt = 0;
            exp_q.delete();
        end else begin
            if (s_in_beat) exp_q.push_back('{e3: f_chain(3, in_data), e2: f_chain(2, in_data), e1: f_chain(1, in_data)});
            model_cnt = model_cnt + int'(s_in_beat) - int'(ob);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && model_cnt > 0; i++) cycle();
        check("drained", exp_q.size(), 0);
    endtask

    // Single beat through an empty pipe: watch it walk the taps, then leave after exactly D edges.
    task automatic run_vec(input vec_t v);
        in_valid  = 1'b1;
        in_data   = v.din;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
        for (int k = 0; k < D; k++) begin
            cycle();
            check("tap_m3", s_taps3[k*W +: W], v.t3[k]);
            check("tap_m2", s_taps2[k*W +: W], v.t2[k]);
            check("tap_m1", s_taps1[k*W +: W], v.t1[k]);
            check("latency_valid_m3", s_ov3, (k == D-1));
            check("latency_valid_m2", s_ov2, (k == D-1));
            check("latency_valid_m1", s_ov1, (k == D-1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        vecs[0] = '{din: 8'h01, t3: {8'h05, 8'h04, 8'h03, 8'h02}, t2: {8'h01, 8'hFE, 8'h01, 8'hFE}, t1: {8'h01, 8'h00, 8'h01, 8'h00}};
        vecs[1] = '{din: 8'hFE, t3: {8'h02, 8'h01, 8'h00, 8'hFF}, t2: {8'hFE, 8'h01, 8'hFE, 8'h01}, t1: {8'h01, 8'h00, 8'h01, 8'h00}};
        vecs[2] = '{din: 8'hA5, t3: {8'hA9, 8'hA8, 8'hA7, 8'hA6}, t2: {8'hA5, 8'h5A, 8'hA5, 8'h5A}, t1: {8'h01, 8'h00, 8'h01, 8'h00}};
        vecs[3] = '{din: 8'h05, t3: {8'h09, 8'h08, 8'h07, 8'h06}, t2: {8'h05, 8'hFA, 8'h05, 8'hFA}, t1: {8'h01, 8'h00, 8'h01, 8'h00}};
        vecs[4] = '{din: 8'h00, t3: {8'h04, 8'h03, 8'h02, 8'h01}, t2: {8'h00, 8'hFF, 8'h00, 8'hFF}, t1: {8'h00, 8'h01, 8'h00, 8'h01}};
        vecs[5] = '{din: 8'hFF, t3: {8'h03, 8'h02, 8'h01, 8'h00}, t2: {8'hFF, 8'h00, 8'hFF, 8'h00}, t1: {8'h01, 8'h00, 8'h01, 8'h00}};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #12;
        check("reset_out_valid", out_valid3, 0);
        check("reset_out_data", out_data3, 0);
        check("reset_taps", taps3, 0);
        check("reset_occupancy", occupancy3, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Single-beat vectors: per-stage values, wrap, and latency.
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        drain();

        // Back-to-back stream with the output stalled for the first six cycles.
        idx = 0;
        for (int c = 0; c < 16; c++) begin
            out_ready = (c >= 6);
            in_valid  = (idx < 10);
            in_data   = 8'(idx);
            cycle();
            if (s_in_beat) idx++;
            if (c == 5) begin
                check("stream_occ_full", s_occ, 4);
                check("stream_accepts_before_ready", idx, 4);
            end
            if (c >= 6) check("stream_no_gap", s_ov3, 1);
        end
        drain();

        // Random valid/ready traffic.
        for (int c = 0; c < 1000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom_range(0, 255));
            cycle();
        end
        drain();

        // Flush with three beats in flight; input offered during flush must be refused.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 8'h10; cycle();
        in_data = 8'h20; cycle();
        in_data = 8'h30; cycle();
        flush = 1'b1; in_data = 8'h77;
        cycle();
        check("flush_pre_occ", s_occ, 3);
        flush = 1'b0; in_valid = 1'b0;
        cycle();
        check("flush_occ", s_occ, 0);
        check("flush_out_valid", s_ov3, 0);
        check("flush_tap0_m3", s_taps3[0*W +: W], 8'h31);
        check("flush_tap1_m3", s_taps3[1*W +: W], 8'h22);
        check("flush_tap2_m3", s_taps3[2*W +: W], 8'h13);
        check("flush_tap0_m2", s_taps2[0*W +: W], 8'hCF);
        check("flush_tap1_m2", s_taps2[1*W +: W], 8'h20);
        check("flush_tap2_m2", s_taps2[2*W +: W], 8'hEF);
        drain();

        // Asynchronous reset in the middle of a cycle with a full pipe.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'h40 + i);
            cycle();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid3, 0);
        check("async_rst_out_data", out_data3, 0);
        check("async_rst_taps", taps3, 0);
        check("async_rst_occupancy", occupancy3, 0);
        model_cnt = 0;
        exp_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        run_vec(vecs[0]);
        run_vec(vecs[1]);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
